axi_lite_master: RTL and testbench

//  AXI-lite initiator. Turns single-beat commands from a local controller into
//  AXI-lite read/write transactions toward a register-file slave, and returns a

---
 rtl/axi_lite_master.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI-lite initiator: turns single-beat local commands into AXI-lite
// read/write transactions and returns one response per command.
// One transaction in flight at a time. Commands complete strictly in order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | awvalid/wvalid offered; each drops after its own handshake
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | arvalid offered, waiting for arready
// RD_DATA | rready high, waiting for read data
// RESP    | rsp_valid high with stable data until rsp_ready
module axi_lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    // local command / response
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // write address channel
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    // write data channel
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    // write response channel
    input  logic                  bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    // read data channel
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    wstrb_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    arvalid_q;
    logic                    bready_q;
    logic                    rready_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    // A write-request beat is still outstanding after this edge when its
    // valid is up and the slave has not taken it yet.
    logic aw_pend;
    logic w_pend;
    assign aw_pend = awvalid_q && !awready;
    assign w_pend  = wvalid_q && !wready;

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign awaddr    = awaddr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;

    // Transaction sequencer: state plus every registered channel output.
    // Addresses and write data are only reloaded on accept, so they stay
    // put for the late-sampling slave through the B/R handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= 1'b1;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                        wstrb_q  <= 1'b0;
                    end
                    if (!aw_pend && !w_pend) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_err_q   <= bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= rdata;
                        rsp_err_q   <= rresp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable register-file slave that
// samples address/data late, a hand-written vector table, a reset-in-flight
// sequence, and randomized commands checked against a memory model.
module tb_axi_lite_master;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic          wstrb;
    logic          wvalid;
    logic          wready = 1'b0;
    logic          bresp = 1'b0;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rresp = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            aw_dly;
        int            w_dly;
        int            ar_dly;
        int            resp_dly;
        bit            err;
        int            hold;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_lat;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int awd, int wd,
                                int ard, int rd, bit e, int h, logic [DW-1:0] xr, bit xe, int xl);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard;
        v.resp_dly = rd; v.err = e; v.hold = h; v.exp_rdata = xr; v.exp_err = xe; v.exp_lat = xl;
        return v;
    endfunction

    // ---------------- slave configuration and observations ----------------
    int            s_aw_dly = 0, s_w_dly = 0, s_ar_dly = 0, s_resp_dly = 0;
    bit            s_err = 1'b0;
    logic [DW-1:0] smem [16];
    int            aw_beats = 0, w_beats = 0, ar_beats = 0;
    logic [AW-1:0] hs_awaddr, late_awaddr, hs_araddr, late_araddr;
    logic [DW-1:0] hs_wdata, late_wdata;
    logic          hs_wstrb;
    int            viol = 0;

    int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit            aw_got, w_got, ar_got, aw_done, w_done, ar_done, b_fire, r_fire;
    bit            p_awv, p_wv, p_arv, wr_live, rd_live;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;

    // Slave: all drive decisions made at negedge, so what is driven here and
    // what the DUT shows now is exactly what the next posedge sees.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0; aw_done = 0; w_done = 0; ar_done = 0;
                b_fire = 0; r_fire = 0; p_awv = 0; p_wv = 0; p_arv = 0; wr_live = 0; rd_live = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0; rresp = 0;
                continue;
            end
            // a valid that fell without its ready being high
            if (p_awv && !awready && !awvalid) viol++;
            if (p_wv && !wready && !wvalid) viol++;
            if (p_arv && !arready && !arvalid) viol++;
            // address/data must not move between issue and B/R handshake
            if (wr_live && (awaddr !== p_awaddr || wdata !== p_wdata)) viol++;
            if (rd_live && (araddr !== p_araddr)) viol++;
            if (!wr_live && awvalid) begin wr_live = 1; p_awaddr = awaddr; p_wdata = wdata; end
            if (!rd_live && arvalid) begin rd_live = 1; p_araddr = araddr; end
            p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;

            if (awready) aw_done = 1;
            if (wready) w_done = 1;
            if (arready) ar_done = 1;
            if (b_fire) begin
                bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; aw_done = 0; w_done = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; wr_live = 0;
            end
            if (r_fire) begin
                rvalid = 0; r_fire = 0; ar_got = 0; ar_done = 0; ar_cnt = 0; r_cnt = 0; rd_live = 0;
            end

            awready = 0; wready = 0; arready = 0;
            if (awvalid && !aw_got) begin
                if (aw_cnt >= s_aw_dly) begin
                    awready = 1; aw_got = 1; aw_beats++; hs_awaddr = awaddr;
                end else aw_cnt++;
            end
            if (wvalid && !w_got) begin
                if (w_cnt >= s_w_dly) begin
                    wready = 1; w_got = 1; w_beats++; hs_wdata = wdata; hs_wstrb = wstrb;
                end else w_cnt++;
            end
            if (arvalid && !ar_got) begin
                if (ar_cnt >= s_ar_dly) begin
                    arready = 1; ar_got = 1; ar_beats++; hs_araddr = araddr;
                end else ar_cnt++;
            end

            if (aw_done && w_done && !bvalid) begin
                if (b_cnt >= s_resp_dly) begin
                    bvalid = 1; bresp = s_err;
                    late_awaddr = awaddr; late_wdata = wdata;
                    if (!s_err) smem[awaddr] = wdata;
                end else b_cnt++;
            end
            if (bvalid && bready) b_fire = 1;

            if (ar_done && !rvalid) begin
                if (r_cnt >= s_resp_dly) begin
                    rvalid = 1; rresp = s_err; rdata = smem[araddr]; late_araddr = araddr;
                end else r_cnt++;
            end
            if (rvalid && rready) r_fire = 1;

            // response fields carry junk whenever their valid is low
            if (!bvalid) bresp = ($urandom & 1) != 0;
            if (!rvalid) begin rresp = ($urandom & 1) != 0; rdata = $urandom; end
        end
    end

    // ---------------- reference memory model ----------------
    logic [DW-1:0] mem_m [16];

    function automatic vec_t model_expect(vec_t v);
        vec_t r = v;
        int   req;
        r.exp_rdata = v.wr ? '0 : mem_m[v.addr];
        r.exp_err   = v.err;
        req         = v.wr ? ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) : v.ar_dly;
        r.exp_lat   = 3 + req + v.resp_dly;
        return r;
    endfunction

    task automatic model_commit(input vec_t v);
        if (v.wr && !v.err) mem_m[v.addr] = v.wdata;
    endtask

    // ---------------- command driver ----------------
    task automatic do_cmd(input vec_t v, input string tag);
        int n;
        int t0;
        s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_ar_dly = v.ar_dly;
        s_resp_dly = v.resp_dly; s_err = v.err;
        aw_beats = 0; w_beats = 0; ar_beats = 0;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = 4'($urandom); cmd_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (!rsp_valid) return;
        check({tag, ".latency"}, 64'(cyc - t0), 64'(v.exp_lat));
        check({tag, ".rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        check({tag, ".err"}, 64'(rsp_err), 64'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            check({tag, ".hold"},
                  {28'd0, rsp_valid, rsp_err, cmd_ready, awvalid | wvalid | arvalid | bready | rready, rsp_rdata},
                  {28'd0, 1'b1, v.exp_err, 1'b0, 1'b0, v.exp_rdata});
            cmd_valid = 1; cmd_write = ~v.wr; cmd_addr = 4'($urandom);
            @(negedge clk);
        end
        cmd_valid = 0; rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, ".post"}, {62'd0, rsp_valid, cmd_ready}, 64'd1);
        if (v.wr) begin
            check({tag, ".beats"}, {32'd0, 8'(aw_beats), 8'(w_beats), 8'(ar_beats), 8'd0}, {32'd0, 8'd1, 8'd1, 8'd0, 8'd0});
            check({tag, ".awaddr"}, {late_awaddr, hs_awaddr}, {v.addr, v.addr});
            check({tag, ".wdata"}, {late_wdata, hs_wdata}, {v.wdata, v.wdata});
            check({tag, ".wstrb"}, 64'(hs_wstrb), 64'd1);
        end else begin
            check({tag, ".beats"}, {32'd0, 8'(aw_beats), 8'(w_beats), 8'(ar_beats), 8'd0}, {32'd0, 8'd0, 8'd0, 8'd1, 8'd0});
            check({tag, ".araddr"}, {late_araddr, hs_araddr}, {v.addr, v.addr});
        end
    endtask

    vec_t tbl [13];

    initial begin
        int   n;
        int   seen;
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            smem[i]  = 32'h5A5A_0000 | 32'(i);
            mem_m[i] = 32'h5A5A_0000 | 32'(i);
        end
        //           wr  addr   wdata          aw w  ar rd err hold  exp_rdata     err lat
        tbl[0]  = mk(1, 4'h4, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 3);
        tbl[1]  = mk(1, 4'h8, 32'h12345678, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 3);
        tbl[2]  = mk(0, 4'h8, 32'h0,        0, 0, 3, 0, 0, 0, 32'h12345678, 0, 6);
        tbl[3]  = mk(1, 4'h4, 32'h0BADF00D, 1, 2, 0, 0, 1, 0, 32'h00000000, 1, 5);
        tbl[4]  = mk(0, 4'h4, 32'h0,        0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 3);
        tbl[5]  = mk(1, 4'hC, 32'hCAFEF00D, 2, 0, 0, 1, 0, 2, 32'h00000000, 0, 6);
        tbl[6]  = mk(0, 4'hC, 32'h0,        0, 0, 0, 2, 1, 0, 32'hCAFEF00D, 1, 5);
        tbl[7]  = mk(0, 4'h0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h5A5A0000, 0, 3);
        tbl[8]  = mk(1, 4'hF, 32'hFFFFFFFF, 0, 3, 0, 0, 0, 0, 32'h00000000, 0, 6);
        tbl[9]  = mk(0, 4'hF, 32'h0,        0, 0, 1, 1, 0, 1, 32'hFFFFFFFF, 0, 5);
        tbl[10] = mk(1, 4'h0, 32'h00000001, 0, 0, 0, 0, 0, 5, 32'h00000000, 0, 3);
        tbl[11] = mk(0, 4'h0, 32'h0,        0, 0, 0, 0, 0, 5, 32'h00000001, 0, 3);
        tbl[12] = mk(0, 4'h5, 32'h0,        0, 0, 0, 0, 0, 0, 32'h5A5A0005, 0, 3);

        // reset values
        repeat (3) @(negedge clk);
        check("reset.ctrl", {56'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, wstrb}, 64'd0);
        check("reset.bus", {awaddr, araddr, wdata, 24'd0}, 64'd0);
        check("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
        #2 resetn = 1;
        @(negedge clk);
        check("reset.cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i], $sformatf("vec%0d", i));
            model_commit(tbl[i]);
        end

        // reset while waiting for the write response: command is dropped
        s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 0; s_resp_dly = 6; s_err = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h5; cmd_wdata = 32'h77777777;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        check("rst_mid.bready", 64'(bready), 64'd1);
        #2 resetn = 0;
        #1;
        check("rst_mid.drop", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
        check("rst_mid.cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_mid.no_rsp", 64'(seen), 64'd0);
        do_cmd(tbl[12], "vec12");

        // randomized commands against the memory model
        for (int i = 0; i < 40; i++) begin
            v.wr       = ($urandom & 1) != 0;
            v.addr     = 4'($urandom_range(0, 15));
            v.wdata    = $urandom;
            v.aw_dly   = int'($urandom_range(0, 3));
            v.w_dly    = int'($urandom_range(0, 3));
            v.ar_dly   = int'($urandom_range(0, 3));
            v.resp_dly = int'($urandom_range(0, 3));
            v.err      = ($urandom_range(0, 3) == 0);
            v.hold     = int'($urandom_range(0, 3));
            v          = model_expect(v);
            do_cmd(v, $sformatf("rnd%0d", i));
            model_commit(v);
        end

        check("protocol_violations", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
